// File: rtl/mux_sel_arb.sv
// Round-robin select arbiter driving a downstream 4:1 mux select.
// Grants are capped at DWELL cycles and separated by one dead cycle.
module mux_sel_arb #(
    parameter int DWELL = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [7:0] DWELL_C = 8'(DWELL);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [3:0] gnt_q, gnt_d;
    logic [7:0] dwell_q, dwell_d;

    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    logic       stop;

    // First requester after the last-granted channel, wrapping 3 -> 0.
    always_comb begin
        pick  = last_q + 2'd1;
        cand  = last_q + 2'd1;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = last_q + 2'(i) + 2'd1;
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign stop = !req[sel_q] || !en || (dwell_q == DWELL_C);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        unique case (state_q)
            IDLE, GAP: begin
                if (en && found) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                    last_d  = pick;
                    dwell_d = 8'd1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            GRANT: begin
                if (stop) begin
                    state_d = GAP;
                    gnt_d   = 4'b0000;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            gnt_q   <= 4'b0000;
            last_q  <= 2'd3;
            dwell_q <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
        end
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = |gnt_q;

endmodule

// File: tb/tb_mux_sel_arb.sv
// Directed bench for mux_sel_arb at DWELL=8 and DWELL=1.
// Expected grant/select values are queued per cycle and popped after each edge.
module tb_mux_sel_arb;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [1:0] sel8, sel1;
    logic [3:0] gnt8, gnt1;
    logic       busy8, busy1;

    int checks = 0;
    int errors = 0;

    exp_t q8[$];
    exp_t q1[$];

    logic [3:0] m_gnt[2];
    logic [1:0] m_sel[2];
    logic [1:0] m_last[2];
    int         m_cnt[2];
    int         lim[2] = '{8, 1};

    mux_sel_arb #(.DWELL(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .req (req),
        .sel (sel8),
        .gnt (gnt8),
        .busy(busy8)
    );

    mux_sel_arb #(.DWELL(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .req (req),
        .sel (sel1),
        .gnt (gnt1),
        .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_gnt[k]  = 4'b0000;
            m_sel[k]  = 2'b00;
            m_last[k] = 2'd3;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic model_step(input int k);
        logic [1:0] c;
        if (m_gnt[k] != 4'b0000) begin
            if (!req[m_sel[k]] || !en || m_cnt[k] == lim[k])
                m_gnt[k] = 4'b0000;
            else
                m_cnt[k]++;
        end else if (en) begin
            for (int i = 1; i <= 4; i++) begin
                c = 2'((int'(m_last[k]) + i) % 4);
                if (req[c]) begin
                    m_gnt[k]  = 4'b0001 << c;
                    m_sel[k]  = c;
                    m_last[k] = c;
                    m_cnt[k]  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_now(input string tag);
        chk({tag, "_gnt8"}, {4'b0, gnt8}, 8'h00);
        chk({tag, "_sel8"}, {6'b0, sel8}, 8'h00);
        chk({tag, "_busy8"}, {7'b0, busy8}, 8'h00);
        chk({tag, "_gnt1"}, {4'b0, gnt1}, 8'h00);
        chk({tag, "_sel1"}, {6'b0, sel1}, 8'h00);
        chk({tag, "_busy1"}, {7'b0, busy1}, 8'h00);
    endtask

    task automatic cyc();
        exp_t e;
        model_step(0);
        model_step(1);
        q8.push_back({m_gnt[0], m_sel[0]});
        q1.push_back({m_gnt[1], m_sel[1]});
        @(posedge clk);
        #1;
        e = q8.pop_front();
        chk("gnt8", {4'b0, gnt8}, {4'b0, e.g});
        chk("sel8", {6'b0, sel8}, {6'b0, e.s});
        chk("busy8", {7'b0, busy8}, {7'b0, |gnt8});
        chk("oh8", {7'b0, $onehot0(gnt8)}, 8'h01);
        e = q1.pop_front();
        chk("gnt1", {4'b0, gnt1}, {4'b0, e.g});
        chk("sel1", {6'b0, sel1}, {6'b0, e.s});
        chk("busy1", {7'b0, busy1}, {7'b0, |gnt1});
        chk("oh1", {7'b0, $onehot0(gnt1)}, 8'h01);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_now("rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        model_reset();

        do_reset();

        // Two-channel alternation with full dwell.
        req = 4'b0101;
        en  = 1'b1;
        cyc();
        chk("r25_first", {4'b0, gnt8}, 8'h01);
        repeat (8) cyc();
        chk("r25_gap", {4'b0, gnt8}, 8'h00);
        cyc();
        chk("r25_next", {4'b0, gnt8}, 8'h04);
        chk("r25_sel", {6'b0, sel8}, 8'h02);

        req = 4'b1111;
        repeat (40) cyc();

        // Granted channel drops its request early.
        do_reset();
        req = 4'b0110;
        en  = 1'b1;
        cyc();
        chk("r27_g1", {4'b0, gnt8}, 8'h02);
        cyc();
        cyc();
        req = 4'b0100;
        cyc();
        chk("r27_gap", {4'b0, gnt8}, 8'h00);
        chk("r27_hold", {6'b0, sel8}, 8'h01);
        cyc();
        chk("r27_g2", {4'b0, gnt8}, 8'h04);

        // Sole requester on channel 3.
        do_reset();
        req = 4'b1000;
        en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("r28_gnt", {4'b0, gnt1}, (i % 2 == 0) ? 8'h08 : 8'h00);
            chk("r28_sel", {6'b0, sel1}, 8'h03);
        end

        // Enable dropped mid-grant.
        req = 4'b0011;
        repeat (3) cyc();
        en = 1'b0;
        cyc();
        chk("r29_drop", {4'b0, gnt8}, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("r29_off", {4'b0, gnt8}, 8'h00);
        end
        en = 1'b1;
        repeat (3) cyc();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                req = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 9) != 0);
            cyc();
        end

        // Asynchronous reset between edges while granted.
        req = 4'b1111;
        en  = 1'b1;
        repeat (3) cyc();
        #2;
        rst = 1'b1;
        #1;
        check_now("r30");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("r30_g0", {4'b0, gnt8}, 8'h01);
        repeat (20) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
